// File: rtl/irrigation_level_ctrl.sv
// Tank-level / soil-dryness sensor conditioning and irrigation valve state machine.
// Raw sensors are synchronized and debounced; valves are decoded from the registered FSM state.
module irrigation_level_ctrl #(
    parameter int DEBOUNCE = 4,
    parameter int FILL_MAX = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic l_raw,
    input  logic m_raw,
    input  logic h_raw,
    input  logic dry_raw,
    input  logic clr,
    output logic l,
    output logic m,
    output logic h,
    output logic vs,
    output logic bs,
    output logic fill,
    output logic err
);

    localparam int NUM_SENSORS = 4;
    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE - 1);
    localparam logic [8:0] PRIME_CYCLES = 9'(DEBOUNCE + 2);
    localparam logic [15:0] FILL_LAST = 16'(FILL_MAX - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SPRINKLE,
        ST_DRIP,
        ST_ERROR
    } state_t;

    logic [NUM_SENSORS-1:0] raw_bits;
    logic [NUM_SENSORS-1:0] deb_bits;

    // Bit order: 0 = low, 1 = medium, 2 = high, 3 = dry.
    assign raw_bits = {dry_raw, h_raw, m_raw, l_raw};

    generate
        for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_sensor
            logic       sync_meta_reg;
            logic       sync_reg;
            logic       deb_reg;
            logic [7:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_meta_reg <= 1'b0;
                    sync_reg      <= 1'b0;
                    deb_reg       <= 1'b0;
                    cnt_reg       <= 8'd0;
                end else begin
                    sync_meta_reg <= raw_bits[gi];
                    sync_reg      <= sync_meta_reg;
                    if (sync_reg != deb_reg) begin
                        // Accept on the DEBOUNCE-th consecutive mismatching cycle.
                        if (cnt_reg == DEB_LAST) begin
                            deb_reg <= sync_reg;
                            cnt_reg <= 8'd0;
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end else begin
                        cnt_reg <= 8'd0;
                    end
                end
            end

            assign deb_bits[gi] = deb_reg;
        end
    endgenerate

    logic   lvl_l;
    logic   lvl_m;
    logic   lvl_h;
    logic   dry;
    logic   inc;
    logic   ready;
    logic   timeout;
    logic [8:0]  prime_reg;
    logic [15:0] fill_timer_reg;
    state_t state_reg;
    state_t state_next;

    assign lvl_l = deb_bits[0];
    assign lvl_m = deb_bits[1];
    assign lvl_h = deb_bits[2];
    assign dry   = deb_bits[3];
    assign inc   = (lvl_h & ~lvl_m) | (lvl_m & ~lvl_l);

    // Debounced levels are meaningless until a full acquisition window has elapsed
    // since reset, so the FSM is held in IDLE until then.
    assign ready   = (prime_reg == PRIME_CYCLES);
    assign timeout = (fill_timer_reg == FILL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_reg      <= 9'd0;
            state_reg      <= ST_IDLE;
            fill_timer_reg <= 16'd0;
        end else begin
            if (!ready) begin
                prime_reg <= prime_reg + 9'd1;
            end
            state_reg <= state_next;
            if ((state_reg == ST_FILL) && (state_next == ST_FILL)) begin
                if (fill_timer_reg != 16'hFFFF) begin
                    fill_timer_reg <= fill_timer_reg + 16'd1;
                end
            end else begin
                fill_timer_reg <= 16'd0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        if (ready) begin
            case (state_reg)
                ST_IDLE: begin
                    if (inc)              state_next = ST_ERROR;
                    else if (!lvl_m)      state_next = ST_FILL;
                    else if (dry & lvl_h) state_next = ST_SPRINKLE;
                    else if (dry)         state_next = ST_DRIP;
                end
                ST_FILL: begin
                    if (inc)          state_next = ST_ERROR;
                    else if (lvl_h)   state_next = ST_IDLE;
                    else if (timeout) state_next = ST_ERROR;
                end
                ST_SPRINKLE: begin
                    if (inc)                 state_next = ST_ERROR;
                    else if (!dry || !lvl_h) state_next = ST_IDLE;
                end
                ST_DRIP: begin
                    if (inc)                 state_next = ST_ERROR;
                    else if (!dry || !lvl_m) state_next = ST_IDLE;
                end
                ST_ERROR: begin
                    if (clr && !inc) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign l    = lvl_l;
    assign m    = lvl_m;
    assign h    = lvl_h;
    assign fill = (state_reg == ST_FILL);
    assign vs   = (state_reg == ST_SPRINKLE);
    assign bs   = (state_reg == ST_DRIP);
    assign err  = (state_reg == ST_ERROR);

endmodule

// File: tb/tb_irrigation_level_ctrl.sv
// Directed bench for irrigation_level_ctrl: default instance plus a short-timeout instance.
module tb_irrigation_level_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic l_raw, m_raw, h_raw, dry_raw, clr;
    logic l, m, h, vs, bs, fill, err;
    logic to_l, to_m, to_h, to_vs, to_bs, to_fill, to_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irrigation_level_ctrl #(.DEBOUNCE(4), .FILL_MAX(200)) dut (
        .clk(clk), .rst_n(rst_n),
        .l_raw(l_raw), .m_raw(m_raw), .h_raw(h_raw), .dry_raw(dry_raw), .clr(clr),
        .l(l), .m(m), .h(h), .vs(vs), .bs(bs), .fill(fill), .err(err)
    );

    irrigation_level_ctrl #(.DEBOUNCE(4), .FILL_MAX(20)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .l_raw(l_raw), .m_raw(m_raw), .h_raw(h_raw), .dry_raw(dry_raw), .clr(clr),
        .l(to_l), .m(to_m), .h(to_h), .vs(to_vs), .bs(to_bs), .fill(to_fill), .err(to_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; l_raw = 1'b0; m_raw = 1'b0; h_raw = 1'b0; dry_raw = 1'b0; clr = 1'b0;

        // Reset state and start-up fill
        tick(2);
        check("rst_outs", {25'd0, l, m, h, vs, bs, fill, err}, 32'd0);
        rst_n = 1'b1;
        tick(6);
        check("start_fill_e6", fill, 0);
        tick(1);
        check("start_fill_e7", fill, 1);
        check("start_others", {vs, bs, err}, 0);
        check("to_start_fill", to_fill, 1);
        $display("txn reset_start done");

        // Timeout instance: fill for exactly 20 cycles then error
        tick(19);
        check("to_fill_last", {to_fill, to_err}, 2'b10);
        tick(1);
        check("to_timeout", {to_fill, to_err}, 2'b01);
        check("main_still_fill", fill, 1);
        $display("txn fill_timeout done");

        // Fill cycle: levels rise 10 cycles apart
        l_raw = 1'b1;
        tick(5);  check("l_e5", l, 0);
        tick(1);  check("l_e6", l, 1);
        tick(4);  m_raw = 1'b1;
        tick(5);  check("m_e5", m, 0);
        tick(1);  check("m_e6", m, 1);
        tick(4);  h_raw = 1'b1;
        tick(6);  check("h_e6", h, 1);
        check("fill_before_stop", fill, 1);
        tick(1);  check("fill_stop", {fill, vs, bs, err}, 4'b0000);
        $display("txn fill_cycle done");

        // Glitch rejection: 3-cycle dropout ignored
        tick(3);
        h_raw = 1'b0; tick(3); h_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("glitch3_h", h, 1);
        end
        check("glitch3_state", {fill, vs, bs, err}, 4'b0000);
        // 4-cycle dropout propagates for 4 cycles
        h_raw = 1'b0; tick(4); h_raw = 1'b1;
        tick(1);  check("glitch4_e5", h, 1);
        tick(1);  check("glitch4_e6", h, 0);
        tick(1);  check("glitch4_e7", {h, fill, err}, 3'b000);
        tick(2);  check("glitch4_e9", h, 0);
        tick(1);  check("glitch4_e10", h, 1);
        $display("txn glitch done");

        // Irrigation: sprinkle, then drip after h drops
        tick(4);
        dry_raw = 1'b1;
        tick(6);  check("vs_e6", vs, 0);
        tick(1);  check("vs_e7", {vs, bs, fill}, 3'b100);
        h_raw = 1'b0;
        tick(6);  check("vs_hold", vs, 1);
        tick(1);  check("sprinkle_to_idle", {vs, bs}, 2'b00);
        tick(1);  check("idle_to_drip", {vs, bs, fill}, 3'b010);
        dry_raw = 1'b0;
        tick(6);  check("bs_hold", bs, 1);
        tick(1);  check("bs_stop", {vs, bs, fill, err}, 4'b0000);
        $display("txn irrigation done");

        // Inconsistency and error acknowledge
        h_raw = 1'b1; m_raw = 1'b0;
        tick(7);  check("inc_err", {err, fill, vs, bs}, 4'b1000);
        clr = 1'b1;
        tick(2);  check("clr_ignored", err, 1);
        clr = 1'b0;
        m_raw = 1'b1;
        tick(7);  check("err_hold_noclr", err, 1);
        clr = 1'b1;
        tick(1);  check("clr_accept", err, 0);
        clr = 1'b0;
        tick(1);  check("idle_after_clr", {err, fill, vs, bs}, 4'b0000);
        $display("txn inconsistency done");

        // Asynchronous reset mid-fill
        l_raw = 1'b0; m_raw = 1'b0; h_raw = 1'b0;
        tick(7);  check("refill", fill, 1);
        #2 rst_n = 1'b0;
        #1 check("async_rst_fill", fill, 0);
        check("async_rst_all", {25'd0, l, m, h, vs, bs, fill, err}, 32'd0);
        $display("txn async_reset done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
